// File: rtl/nes_multi_pad.sv
// Polls up to four NES controllers in parallel over a shared latch/clock pair
// and publishes their debounced button bytes and one-cycle press-edge flags.
module nes_multi_pad #(
  parameter int NUM_PADS   = 2,
  parameter int CLK_DIV    = 300,
  parameter int POLL_TICKS = 2778
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PADS-1:0]   nesData,
  input  logic [1:0]            padSel,
  output logic                  nesClock,
  output logic                  nesLatch,
  output logic [8*NUM_PADS-1:0] buttons,
  output logic [8*NUM_PADS-1:0] pressed,
  output logic                  frameDone,
  output logic [15:0]           assemblyButton
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int POLL_W = $clog2(POLL_TICKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_DONE} state_t;

  state_t                  r_state;
  logic [DIV_W-1:0]        r_div;
  logic [POLL_W-1:0]       r_idle;
  logic                    r_latch_cnt;
  logic [2:0]              r_k;
  logic [8*NUM_PADS-1:0]   r_shift;
  logic                    w_tick;
  logic [8*NUM_PADS-1:0]   w_shift_next;

  assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

  // Every pad's current bit lands in slot k of its own byte in the same edge.
  always_comb begin
    w_shift_next = r_shift;
    for (int i = 0; i < NUM_PADS; i++) begin
      w_shift_next[8*i + int'(r_k)] = ~nesData[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_idle      <= '0;
      r_latch_cnt <= 1'b0;
      r_k         <= 3'd0;
      r_shift     <= '0;
      nesClock    <= 1'b0;
      nesLatch    <= 1'b0;
      buttons     <= '0;
      pressed     <= '0;
      frameDone   <= 1'b0;
    end else begin
      r_div     <= w_tick ? '0 : r_div + DIV_W'(1);
      pressed   <= '0;
      frameDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            if (r_idle == POLL_W'(POLL_TICKS - 1)) begin
              r_idle      <= '0;
              r_latch_cnt <= 1'b0;
              nesLatch    <= 1'b1;
              r_state     <= S_LATCH;
            end else begin
              r_idle <= r_idle + POLL_W'(1);
            end
          end
        end
        S_LATCH: begin
          if (w_tick) begin
            if (r_latch_cnt) begin
              nesLatch <= 1'b0;
              r_k      <= 3'd0;
              r_state  <= S_LOW;
            end else begin
              r_latch_cnt <= 1'b1;
            end
          end
        end
        S_LOW: begin
          if (w_tick) begin
            r_shift <= w_shift_next;
            if (r_k == 3'd7) begin
              // Results are loaded on entry so they are visible throughout the DONE cycle.
              buttons   <= w_shift_next;
              pressed   <= w_shift_next & ~buttons;
              frameDone <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              nesClock <= 1'b1;
              r_state  <= S_HIGH;
            end
          end
        end
        S_HIGH: begin
          if (w_tick) begin
            nesClock <= 1'b0;
            r_k      <= r_k + 3'd1;
            r_state  <= S_LOW;
          end
        end
        S_DONE: begin
          r_idle  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    assemblyButton = 16'h0000;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (padSel == 2'(i)) assemblyButton[7:0] = buttons[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_nes_multi_pad.sv
// Bench for nes_multi_pad: emulated NES pads feed randomized button bytes, a
// scoreboard checks each completed frame and the CPU word on every cycle.
module tb_nes_multi_pad;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  nes_data;
  logic [1:0]  padSel, padSel1;
  logic        nesClock, nesLatch, frameDone;
  logic [15:0] buttons, pressed, assemblyButton;
  logic        nesClock1, nesLatch1, frameDone1;
  logic [7:0]  buttons1, pressed1;
  logic [15:0] assemblyButton1;

  always #5 clk = ~clk;

  nes_multi_pad #(.NUM_PADS(2), .CLK_DIV(4), .POLL_TICKS(3)) dut (
    .clk(clk), .reset(reset), .nesData(nes_data), .padSel(padSel),
    .nesClock(nesClock), .nesLatch(nesLatch), .buttons(buttons),
    .pressed(pressed), .frameDone(frameDone), .assemblyButton(assemblyButton));

  nes_multi_pad #(.NUM_PADS(1), .CLK_DIV(4), .POLL_TICKS(3)) dut1 (
    .clk(clk), .reset(reset), .nesData(nes_data[0:0]), .padSel(padSel1),
    .nesClock(nesClock1), .nesLatch(nesLatch1), .buttons(buttons1),
    .pressed(pressed1), .frameDone(frameDone1), .assemblyButton(assemblyButton1));

  int nchecks = 0;
  int nfail   = 0;
  int cyc_g   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] b;
    logic [15:0] p;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [15:0] dirq[$];
  logic        toggle_mode = 1'b0;

  always @(posedge clk) cyc_g <= cyc_g + 1;

  initial begin
    padSel  = 2'd0;
    padSel1 = 2'd0;
    forever begin
      @(posedge clk);
      #2;
      padSel  = 2'($urandom);
      padSel1 = 2'($urandom);
    end
  end

  // Pad emulator: behaves like a 4021 shift register behind each connector.
  logic [15:0] cur = 16'h0;
  logic [15:0] prev_bits = 16'h0;
  int          k = 0;
  logic        latch_d = 1'b0, clk_d = 1'b0;
  initial nes_data = 2'b11;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      prev_bits = 16'h0;
      k = 0;
      nes_data = 2'b11;
    end else begin
      if (nesLatch && !latch_d) begin
        exp_t e;
        if (dirq.size() > 0) cur = dirq.pop_front();
        else cur = 16'($urandom);
        e.b = cur;
        e.p = cur & ~prev_bits;
        e.due = cyc_g + 68;
        q.push_back(e);
        prev_bits = cur;
      end
      if (nesLatch) k = 0;
      else if (nesClock && !clk_d && k < 7) k++;
      if (toggle_mode && (nesClock || nesLatch)) nes_data = 2'($urandom);
      else nes_data = ~{cur[8+k], cur[k]};
    end
    latch_d = nesLatch;
    clk_d   = nesClock;
  end

  // Monitor / scoreboard.
  logic [15:0] model = 16'h0;
  always @(negedge clk) begin
    if (reset) begin
      model = 16'h0;
    end else begin
      if (frameDone) begin
        if (q.size() == 0) begin
          nchecks++;
          nfail++;
          $display("FAIL unexpected_frameDone: got frameDone=1 expected no frame pending (t=%0t)", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("frame_time", cyc_g, e.due);
          chk("buttons", {16'h0, buttons}, {16'h0, e.b});
          chk("pressed", {16'h0, pressed}, {16'h0, e.p});
          chk("pad1_frameDone", {31'h0, frameDone1}, 32'd1);
          chk("pad1_buttons", {24'h0, buttons1}, {24'h0, e.b[7:0]});
          chk("pad1_pressed", {24'h0, pressed1}, {24'h0, e.p[7:0]});
          model = e.b;
        end
      end else begin
        chk("pressed_idle", {16'h0, pressed}, 32'h0);
        chk("pad1_idle", {23'h0, frameDone1, pressed1}, 32'h0);
      end
      chk("assemblyButton", {16'h0, assemblyButton},
          (padSel == 2'd0) ? {24'h0, model[7:0]} :
          (padSel == 2'd1) ? {24'h0, model[15:8]} : 32'h0);
      chk("assemblyButton_1pad", {16'h0, assemblyButton1},
          (padSel1 == 2'd0) ? {24'h0, model[7:0]} : 32'h0);
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_pins"}, {30'h0, nesClock, nesLatch}, 32'h0);
    chk({nm, "_buttons"}, {16'h0, buttons}, 32'h0);
    chk({nm, "_pressed_done"}, {15'h0, frameDone, pressed}, 32'h0);
    chk({nm, "_assembly"}, {16'h0, assemblyButton}, 32'h0);
    chk({nm, "_pad1"}, {5'h0, nesClock1, nesLatch1, frameDone1, buttons1, pressed1, 8'h0}, 32'h0);
  endtask

  // Called right after reset is released on a falling edge.
  task automatic measure_frame();
    int cyc = 0, latch_first = -1, latch_len = 0, pulses = 0, done_cyc = -1;
    int plen = 0, pmin = 1000, pmax = 0;
    logic ck_d = 1'b0;
    while (done_cyc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (nesLatch) begin
        latch_len++;
        if (latch_first < 0) latch_first = cyc;
      end
      if (nesClock) begin
        if (!ck_d) pulses++;
        plen++;
      end else if (ck_d) begin
        if (plen < pmin) pmin = plen;
        if (plen > pmax) pmax = plen;
        plen = 0;
      end
      ck_d = nesClock;
      if (frameDone) done_cyc = cyc;
    end
    chk("latch_rise_cycle", latch_first, 12);
    chk("latch_high_len", latch_len, 8);
    chk("clock_pulses", pulses, 7);
    chk("clock_pulse_min", pmin, 4);
    chk("clock_pulse_max", pmax, 4);
    chk("frameDone_cycle", done_cyc, 80);
  endtask

  task automatic wait_frames(input int n);
    int seen = 0, cyc = 0;
    while (seen < n && cyc < 200 * n) begin
      @(negedge clk);
      cyc++;
      if (frameDone) seen++;
    end
    chk("frames_seen", seen, n);
  endtask

  initial begin
    int rises, cyc;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_zero("in_reset");

    dirq.push_back(16'h0000);
    @(negedge clk) reset = 1'b0;
    measure_frame();

    dirq.push_back(16'h8009);
    dirq.push_back(16'h8009);
    wait_frames(2);
    wait_frames(6);

    toggle_mode = 1'b1;
    dirq.push_back(16'hFFFF);
    wait_frames(3);
    toggle_mode = 1'b0;

    dirq.push_back(16'hA5C3);
    cyc = 0;
    while (!nesLatch && cyc < 200) begin @(negedge clk); cyc++; end
    rises = 0;
    while (rises < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (nesClock && !clk_d) rises++;
    end
    chk("reached_bit3_high", rises, 4);
    reset = 1'b1;
    @(posedge clk);
    #1 check_zero("mid_frame_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    measure_frame();
    wait_frames(3);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nes_multi_pad.md
NES_MULTI_PAD -- requirements
Module: nes_multi_pad

Interface
REQ-001 Parameter NUM_PADS, default 2: number of NES controllers polled in parallel, legal 1..4.
REQ-002 Parameter CLK_DIV, default 300: clk cycles per protocol tick (6 us at 50 MHz), legal >= 2.
REQ-003 Parameter POLL_TICKS, default 2778: idle ticks between poll frames (~16.7 ms), legal >= 1.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 nesData  input  NUM_PADS  serial data per pad, active-low (0 = pressed); bit i = pad i.
REQ-007 padSel  input  2  pad index routed to assemblyButton.
REQ-008 nesClock  output  1  shared NES shift clock, idle low.
REQ-009 nesLatch  output  1  shared NES latch, idle low.
REQ-010 buttons  output  8*NUM_PADS  debounced state, active-high; byte i = pad i, bit order [0]=A,[1]=B,[2]=Select,[3]=Start,[4]=Up,[5]=Down,[6]=Left,[7]=Right.
REQ-011 pressed  output  8*NUM_PADS  one-cycle press-edge flags, same layout as buttons.
REQ-012 frameDone  output  1  one-cycle pulse when buttons/pressed update.
REQ-013 assemblyButton  output  16  CPU IO word: {8'b0, buttons byte of pad padSel}.

Function
REQ-014 Tick counter SHALL count 0..CLK_DIV-1 and wrap; tick is asserted in the cycle count == CLK_DIV-1; all FSM transitions except DONE->IDLE occur only on tick.
REQ-015 FSM states SHALL be IDLE, LATCH, LOW, HIGH, DONE.
REQ-016 IDLE: nesLatch=0, nesClock=0; counts ticks; after POLL_TICKS ticks -> LATCH.
REQ-017 LATCH: nesLatch=1, nesClock=0 for exactly 2 ticks -> LOW with bit index k=0.
REQ-018 LOW: nesLatch=0, nesClock=0 for 1 tick; on the expiring tick sample ~nesData[i] into shift bit k of every pad i simultaneously.
REQ-019 From LOW: if k<7 -> HIGH; if k==7 -> DONE.
REQ-020 HIGH: nesClock=1 for 1 tick, then k increments and -> LOW.
REQ-021 Frame length SHALL be 2 latch + 8 low + 7 high = 17 ticks; exactly 7 nesClock high pulses per frame.
REQ-022 DONE lasts exactly one clk cycle regardless of tick: buttons <= shift contents, pressed <= shift & ~buttons(old), frameDone=1; then -> IDLE with idle tick count cleared.
REQ-023 pressed and frameDone SHALL be 0 in every cycle other than DONE.
REQ-024 A button held across frames SHALL assert pressed only in the first frame it is seen; release produces no pulse.
REQ-025 assemblyButton SHALL be combinational from buttons and padSel; padSel >= NUM_PADS yields 16'h0000.
REQ-026 Unused upper bits of assemblyButton SHALL always be 0.
REQ-027 nesData changes outside the LOW sampling cycle SHALL have no effect.

Reset
REQ-028 While reset=1 on a clk edge: state=IDLE, tick count=0, idle count=0, k=0, shift register=0.
REQ-029 Reset values: nesClock=0, nesLatch=0, buttons=0, pressed=0, frameDone=0, assemblyButton=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no buttons update; first post-reset latch after POLL_TICKS full ticks.

Verification (CLK_DIV=4, POLL_TICKS=3, NUM_PADS=2 unless noted)
REQ-031 Reset release, nesData=2'b11 -> nesLatch rises after 12 clk cycles, high 8 cycles; 7 nesClock pulses of 4 cycles; frameDone at cycle 80; buttons=16'h0000.
REQ-032 Pad0 drives A,Start low (bits 0,3), pad1 drives Right low -> buttons=16'h8009, pressed=16'h8009 for one cycle; padSel=0 -> assemblyButton=16'h0009; padSel=1 -> 16'h0080.
REQ-033 Same inputs held for a second frame -> buttons=16'h8009, pressed=16'h0000 at that frameDone.
REQ-034 Reset asserted during HIGH of bit 3 -> next cycle nesClock=0, nesLatch=0, all outputs 0; no frameDone until full 3-tick idle plus new frame.
REQ-035 padSel=2 or 3 with any buttons -> assemblyButton=16'h0000; NUM_PADS=1 build -> buttons width 8, padSel=1 -> 16'h0000.
REQ-036 nesData toggled in HIGH cycles only, steady low in LOW sample cycles -> buttons=8'hFF per pad.
